// File: rtl/writeback_queue.sv
// Circular write-back queue committing {addr,data} entries to a register bank in order, one per cycle.
// Latency: push at edge N drives reg_we from N, commits at N+1; backpressure: wr_ready = (count < DEPTH).
// Optional read bypass of queued data under WRITEBACK_QUEUE_BYPASS_EN (default: rd_data_out = rd_data_in).
module writeback_queue #(
    parameter int REG_N = 8,
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(REG_N)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       drain_en,
    input  logic                       flush,
    output logic [REG_N-1:0]           reg_we,
    output logic [WIDTH-1:0]           reg_wdata,
    input  logic [$clog2(REG_N)-1:0]   rd_addr,
    input  logic [WIDTH-1:0]           rd_data_in,
    output logic [WIDTH-1:0]           rd_data_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(REG_N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic active;
    logic push;
    logic pop;

    assign wr_ready = (int'(count_q) < DEPTH);
    assign active   = (count_q != '0) && drain_en;
    // Flush wins over both queue operations, but reg_we still reflects the head.
    assign push     = wr_valid && wr_ready && !flush;
    assign pop      = active && !flush;
    assign count    = count_q;

    always_comb begin
        reg_we    = '0;
        reg_wdata = '0;
        if (active) begin
            reg_we[addr_q[head_q]] = 1'b1;
            reg_wdata              = data_q[head_q];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                addr_q[tail_q] <= wr_addr;
                data_q[tail_q] <= wr_data;
            end
        end
    end

`ifdef WRITEBACK_QUEUE_BYPASS_EN
    logic [PW-1:0] bp_idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        rd_data_out = rd_data_in;
        bp_idx      = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            bp_idx = head_q + PW'(k);
            if ((k < int'(count_q)) && (addr_q[bp_idx] == rd_addr)) begin
                rd_data_out = data_q[bp_idx];
            end
        end
    end
`else
    assign rd_data_out = rd_data_in;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Randomized and directed bench for writeback_queue against a queue-based reference model.
module tb_writeback_queue;

    localparam int REG_N = 8;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        drain_en;
    logic        flush;
    logic [7:0]  reg_we;
    logic [15:0] reg_wdata;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data_in;
    logic [15:0] rd_data_out;
    logic [2:0]  count;

    int tests;
    int fails;
    entry_t q[$];

    writeback_queue #(.REG_N(REG_N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .drain_en    (drain_en),
        .flush       (flush),
        .reg_we      (reg_we),
        .reg_wdata   (reg_wdata),
        .rd_addr     (rd_addr),
        .rd_data_in  (rd_data_in),
        .rd_data_out (rd_data_out),
        .count       (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_rd();
        logic [15:0] r;
        r = rd_data_in;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
        foreach (q[i]) if (q[i].a == rd_addr) r = q[i].d;
`endif
        return r;
    endfunction

    task automatic check_outputs();
        logic [7:0] exp_we;
        logic       act;
        act    = (q.size() > 0) && drain_en;
        exp_we = act ? (8'b1 << q[0].a) : 8'b0;
        check("reg_we", 32'(reg_we), 32'(exp_we));
        if (act) check("reg_wdata", 32'(reg_wdata), 32'(q[0].d));
        check("count", 32'(count), 32'(q.size()));
        check("wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
        check("rd_data_out", 32'(rd_data_out), 32'(model_rd()));
    endtask

    task automatic step(input logic v, input logic [2:0] a, input logic [15:0] d,
                        input logic dr, input logic fl, input logic [2:0] ra,
                        input logic [15:0] rdi);
        logic act;
        logic acc;
        entry_t e;
        wr_valid   = v;
        wr_addr    = a;
        wr_data    = d;
        drain_en   = dr;
        flush      = fl;
        rd_addr    = ra;
        rd_data_in = rdi;
        #1;
        check_outputs();
        act = (q.size() > 0) && dr;
        acc = v && (q.size() < DEPTH);
        e.a = a;
        e.d = d;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (act) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        drain_en   = 1'b1;
        flush      = 1'b0;
        rd_addr    = 3'd2;
        rd_data_in = 16'h5A5A;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_reg_we", 32'(reg_we), 32'd0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        check("rst_rd_data_out", 32'(rd_data_out), 32'h5A5A);
        @(negedge clk);
        reset = 1'b1;

        // Single write, drained immediately.
        step(1'b1, 3'd3, 16'h1234, 1'b1, 1'b0, 3'd0, 16'h0);
        check("single_we", 32'(reg_we), 32'h08);
        check("single_wdata", 32'(reg_wdata), 32'h1234);
        step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);
        check("single_we_done", 32'(reg_we), 32'h00);
        check("single_count", 32'(count), 32'd0);
        step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);

        // Fill with drain stalled, fifth offer refused, then drain in order.
        for (int i = 0; i < 5; i++)
            step(1'b1, 3'(i + 1), 16'(16'h1000 + i), 1'b0, 1'b0, 3'd0, 16'h0);
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(wr_ready), 32'd0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);

        // Two queued, then simultaneous push/pop across the pointer wrap.
        step(1'b1, 3'd6, 16'h2000, 1'b0, 1'b0, 3'd0, 16'h0);
        step(1'b1, 3'd7, 16'h2001, 1'b0, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'(i), 16'(16'h2100 + i), 1'b1, 1'b0, 3'd0, 16'h0);
            check("pushpop_count", 32'(count), 32'd2);
        end
        for (int i = 0; i < 3; i++)
            step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);

        // Flush with a simultaneous write offer.
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'(i + 4), 16'(16'h3000 + i), 1'b0, 1'b0, 3'd0, 16'h0);
        step(1'b1, 3'd1, 16'h3FFF, 1'b0, 1'b1, 3'd0, 16'h0);
        check("flush_count", 32'(count), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);
            check("flush_no_we", 32'(reg_we), 32'd0);
        end

        // Read bypass of the youngest matching entry.
        step(1'b1, 3'd5, 16'hAAAA, 1'b0, 1'b0, 3'd5, 16'h0);
        step(1'b1, 3'd5, 16'hBBBB, 1'b0, 1'b0, 3'd5, 16'h0);
        rd_addr    = 3'd5;
        rd_data_in = 16'h0;
        #1;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
        check("bypass_rd", 32'(rd_data_out), 32'hBBBB);
`else
        check("bypass_rd", 32'(rd_data_out), 32'h0000);
`endif
        step(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 3'd5, 16'h0);

        // Asynchronous reset mid-drain at count 3.
        for (int i = 0; i < 4; i++)
            step(1'b1, 3'(i), 16'(16'h4000 + i), 1'b0, 1'b0, 3'd0, 16'h0);
        step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);
        check("pre_reset_count", 32'(count), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_reg_we", 32'(reg_we), 32'd0);
        check("arst_wr_ready", 32'(wr_ready), 32'd1);
        q.delete();
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 99) < 60), 3'($urandom), 16'($urandom),
                 1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 99) < 4),
                 3'($urandom), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter REG_N, default 8: number of architectural registers; power of two, at least 2.
REQ-002 Parameter WIDTH, default 16: register data width in bits.
REQ-003 Parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-004 Port clk, input, 1: single clock, rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port wr_valid, input, 1: producer offers a write-back.
REQ-007 Port wr_ready, output, 1: queue accepts the offered write-back.
REQ-008 Port wr_addr, input, $clog2(REG_N): destination register index.
REQ-009 Port wr_data, input, WIDTH: destination register data.
REQ-010 Port drain_en, input, 1: commit permitted this cycle; 0 stalls commits.
REQ-011 Port flush, input, 1: synchronous discard of all queued entries.
REQ-012 Port reg_we, output, REG_N: one-hot register write select, driven to the register bank.
REQ-013 Port reg_wdata, output, WIDTH: data for the selected register.
REQ-014 Port rd_addr, input, $clog2(REG_N): read index, also applied to the register-bank read mux.
REQ-015 Port rd_data_in, input, WIDTH: register-bank read mux output.
REQ-016 Port rd_data_out, output, WIDTH: read data returned to the consumer.
REQ-017 Port count, output, $clog2(DEPTH+1): number of occupied entries.

Function
REQ-018 Storage is a circular FIFO of DEPTH {addr, data} entries; head and tail pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-019 wr_ready shall equal (count < DEPTH); there is no same-cycle pass-through when the queue is full.
REQ-020 A push occurs at a rising edge when wr_valid and wr_ready are both 1; the entry is written at the tail and the tail advances.
REQ-021 While count > 0 and drain_en = 1, reg_we shall be one-hot at the head address and reg_wdata shall equal the head data; otherwise reg_we shall be all zeros.
REQ-022 A pop occurs at the rising edge that ends a cycle with nonzero reg_we; the head advances in the same edge as the register-bank capture.
REQ-023 Latency: a write pushed at edge N drives reg_we from edge N onward and is committed at edge N+1 at the earliest; an empty queue therefore commits in 2 edges.
REQ-024 On a simultaneous push and pop, count is unchanged and both pointers advance.
REQ-025 Commit order equals acceptance order; repeated writes to one address are committed in order.
REQ-026 With flush = 1, at the next edge count, head, and tail become 0; flush overrides any push or pop in that cycle, and reg_we is still driven combinationally during the flush cycle.
REQ-027 Without bypass, rd_data_out shall equal rd_data_in combinationally.

Reset
REQ-028 When reset = 0, count, head, tail, and all entry storage shall clear to 0 immediately, independent of clk.
REQ-029 During reset, wr_ready = 1 and reg_we = 0; reg_wdata = 0, and rd_data_out follows rd_data_in.
REQ-030 If reset asserts mid-operation, queued writes are lost and partial commits do not occur.

Configuration
REQ-031 Macro WRITEBACK_QUEUE_BYPASS_EN: when defined, rd_data_out shall return the data of the youngest queued entry whose addr equals rd_addr, including the head entry being committed, and rd_data_in otherwise.
REQ-032 When WRITEBACK_QUEUE_BYPASS_EN is undefined, REQ-027 applies and no address-compare logic is generated.

Verification
REQ-033 Reset, then push addr 3 with data 0x1234 while drain_en = 1 -> reg_we = 8'b0000_1000 and reg_wdata = 0x1234 for exactly one cycle, then count = 0.
REQ-034 Hold drain_en = 0 and push 4 entries -> count = 4, wr_ready = 0; a fifth wr_valid is not accepted; raising drain_en commits the 4 entries in order over 4 cycles.
REQ-035 Queue at count = 2, then push and pop in the same cycle -> count stays 2, and the pointer wrap at DEPTH-1 produces the correct commit order.
REQ-036 Queue 3 entries with drain_en = 0, assert flush together with wr_valid -> count = 0 next cycle, no reg_we pulse afterward, and the new entry is dropped.
REQ-037 With bypass, drain_en = 0, push addr 5 = 0xAAAA then addr 5 = 0xBBBB, rd_addr = 5, rd_data_in = 0x0000 -> rd_data_out = 0xBBBB; without bypass -> 0x0000.
REQ-038 Assert reset while count = 3 mid-drain -> count = 0, reg_we = 0, and wr_ready = 1 with no clock edge required.
